tile_draw_ctrl: RTL and testbench
=================================

# tile_draw_ctrl

Sequencer that paints one 16x16 tile sprite into the pixel-write path of the Pac-Man display. On a start request it walks the tile's sprite ROM coordinates in raster order and reads the combinational r/g/b lookup. It then emits one screen-addressed pixel per cycle through a valid/ready handshake toward the framebuffer writer. It sits between the maze/game-state logic, which issues tile draw requests, and the framebuffer write port.

## Interface
- TILE_COLS, 40, number of tile columns on screen (640 / 16)
- TILE_ROWS, 30, number of tile rows on screen (480 / 16)

- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  draw request; sampled only in IDLE
- tile_col  in  6  tile column of request
- tile_row  in  5  tile row of request
- busy  out  1  high in DRAW and DRAIN
- done  out  1  one-cycle pulse when tile complete
- rom_x  out  4  sprite ROM column address (combinational ROM)
- rom_y  out  4  sprite ROM row address
- rom_r, rom_g, rom_b  in  8 each  ROM colour for (rom_x, rom_y), same cycle
- pix_valid  out  1  output pixel register holds a pixel
- pix_ready  in  1  framebuffer writer accepts pixel this cycle
- pix_x  out  10  screen x = {tile_col_latched, x}
- pix_y  out  9  screen y = {tile_row_latched, y}
- pix_r, pix_g, pix_b  out  8 each  pixel colour

## Operation
- States: IDLE, DRAW, DRAIN, DONE.
- IDLE: start=1 latches tile_col and tile_row, clears the x/y counters, and moves to DRAW.
  - If the latched column is >= TILE_COLS or the row is >= TILE_ROWS, the block goes straight to DONE with no pixel writes.
- DRAW: rom_x/rom_y are driven from the counters.
  - Load condition: (!pix_valid || pix_ready).
  - On a load, the output register captures ROM colour and screen coordinates, pix_valid=1, and the counter advances.
  - Advance order: x increments; at x=15, x wraps to 0 and y increments.
  - Loading (15,15) moves to DRAIN.
- DRAIN: holds until the last pixel handshakes (pix_ready=1), clears pix_valid, then moves to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored in DRAW, DRAIN and DONE. There is no queueing; the requester waits for done or for !busy.
- While pix_valid=1 and pix_ready=0, all pix_* outputs stay stable and the counters hold.
- Screen coordinates are formed by concatenation. There is no arithmetic carry; widths are exact (6+4=10, 5+4=9).
- Reset, at any time including mid-tile: state=IDLE, busy=0, done=0, pix_valid=0, pix_x/pix_y/pix_r/pix_g/pix_b=0, counters=0, rom_x/rom_y=0. A partial tile is abandoned with no further writes.

## Timing
- Start sampled at edge E0 puts the block in DRAW after E0.
- First pix_valid is high after E1.
- With pix_ready held at 1:
  - pixels 0..255 are loaded at E1..E256
  - the last handshake occurs at E257
  - done is high between E257 and E258
  - IDLE is reached after E258
  - throughput is 1 pixel per cycle
- Each cycle pix_ready=0 while pix_valid=1 adds exactly one cycle.
- An out-of-range request gives done high between E1 and E2.
- ROM access is zero-latency: colour is captured on the same edge as its address.

## Configuration
- TILE_TRANSPARENT_EN defined:
  - A ROM pixel with r=g=b=0 is not loaded; pix_valid stays 0 for that slot.
  - The counter still advances in one cycle whenever the load condition holds.
  - DRAIN and done behave as normal; an all-black tile finishes with zero handshakes, and done is high between E257 and E258.
- Not defined: all 256 pixels are emitted regardless of colour.

## Test plan
- pix_ready=1, start with tile_col=2, tile_row=3 -> 256 pixels.
  - First pixel at (32,48) = ROM(0,0); pixel 16 at (32,49); last at (47,63).
  - done high between E257 and E258; busy low after done.
- Same request with pix_ready toggled 1,0,1,0 -> every pixel is delivered once, in raster order, and held stable while stalled; done occurs 256 stall cycles later.
- start asserted in DRAW with a different tile_col -> ignored; coordinates remain those of the first tile.
- reset pulsed after the 100th handshake -> next cycle pix_valid=0, busy=0, all outputs 0; a new start draws the full tile from (0,0).
- tile_col=40, tile_row=0 -> no pix_valid; done high between E1 and E2.
- TILE_TRANSPARENT_EN with a ROM containing 200 black pixels -> exactly 56 handshakes, in raster order; done still high between E257 and E258 with ready=1.

Source files
------------

// File: rtl/tile_draw_ctrl.sv
// Streams one 16x16 sprite tile as screen-addressed pixels over a valid/ready port.
// Optional macro TILE_TRANSPARENT_EN: black ROM pixels are skipped instead of written.
module tile_draw_ctrl #(
    parameter int TILE_COLS = 40,
    parameter int TILE_ROWS = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] tile_col,
    input  logic [4:0] tile_row,
    output logic       busy,
    output logic       done,
    output logic [3:0] rom_x,
    output logic [3:0] rom_y,
    input  logic [7:0] rom_r,
    input  logic [7:0] rom_g,
    input  logic [7:0] rom_b,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic [9:0] pix_x,
    output logic [8:0] pix_y,
    output logic [7:0] pix_r,
    output logic [7:0] pix_g,
    output logic [7:0] pix_b
);

    localparam logic [6:0] LP_COLS = 7'(TILE_COLS);
    localparam logic [6:0] LP_ROWS = 7'(TILE_ROWS);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DRAIN, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_col;
    logic [4:0]  r_row;
    logic [3:0]  r_x;
    logic [3:0]  r_y;
    logic        r_vld_p1;
    logic [9:0]  r_pix_x_p1;
    logic [8:0]  r_pix_y_p1;
    logic [7:0]  r_pix_r_p1;
    logic [7:0]  r_pix_g_p1;
    logic [7:0]  r_pix_b_p1;
    logic        w_load;
    logic        w_oob;
    logic        w_last;
    logic        w_opaque;

`ifdef TILE_TRANSPARENT_EN
    function automatic logic is_opaque(input logic [7:0] r, input logic [7:0] g,
                                       input logic [7:0] b);
        return (r | g | b) != 8'd0;
    endfunction

    assign w_opaque = is_opaque(rom_r, rom_g, rom_b);
`else
    assign w_opaque = 1'b1;
`endif

    // The output register may take a new pixel when it is empty or being drained this edge.
    assign w_load = !r_vld_p1 || pix_ready;
    assign w_oob  = ({1'b0, r_col} >= LP_COLS) || ({2'b00, r_row} >= LP_ROWS);
    assign w_last = (r_x == 4'hF) && (r_y == 4'hF);

    assign rom_x     = r_x;
    assign rom_y     = r_y;
    assign pix_valid = r_vld_p1;
    assign pix_x     = r_pix_x_p1;
    assign pix_y     = r_pix_y_p1;
    assign pix_r     = r_pix_r_p1;
    assign pix_g     = r_pix_g_p1;
    assign pix_b     = r_pix_b_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_DRAW;
            S_DRAW: begin
                if (w_oob) begin
                    w_next = S_DONE;
                end else if (w_load && w_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: if (w_load) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_DRAW:  busy = 1'b1;
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // ---- stage p1: ROM colour captured with its address, screen coords by concatenation
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col      <= '0;
            r_row      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_vld_p1   <= 1'b0;
            r_pix_x_p1 <= '0;
            r_pix_y_p1 <= '0;
            r_pix_r_p1 <= '0;
            r_pix_g_p1 <= '0;
            r_pix_b_p1 <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_col <= tile_col;
                        r_row <= tile_row;
                        r_x   <= '0;
                        r_y   <= '0;
                    end
                end
                S_DRAW: begin
                    if (!w_oob && w_load) begin
                        r_vld_p1 <= w_opaque;
                        if (w_opaque) begin
                            r_pix_x_p1 <= {r_col, r_x};
                            r_pix_y_p1 <= {r_row, r_y};
                            r_pix_r_p1 <= rom_r;
                            r_pix_g_p1 <= rom_g;
                            r_pix_b_p1 <= rom_b;
                        end
                        r_x <= r_x + 4'd1;
                        if (r_x == 4'hF) begin
                            r_y <= r_y + 4'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pix_ready) begin
                        r_vld_p1 <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_draw_ctrl.sv
// Randomized bench for tile_draw_ctrl against a raster-order pixel-list model.
module tb_tile_draw_ctrl;

    localparam int TILE_COLS = 40;
    localparam int TILE_ROWS = 30;
`ifdef TILE_TRANSPARENT_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    typedef logic [42:0] pix_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] tile_col;
    logic [4:0] tile_row;
    logic       busy;
    logic       done;
    logic [3:0] rom_x;
    logic [3:0] rom_y;
    logic [7:0] rom_r;
    logic [7:0] rom_g;
    logic [7:0] rom_b;
    logic       pix_valid;
    logic       pix_ready;
    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic [7:0] pix_r;
    logic [7:0] pix_g;
    logic [7:0] pix_b;

    logic [23:0] rom_mem [256];
    pix_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    assign {rom_r, rom_g, rom_b} = rom_mem[{rom_y, rom_x}];

    always #5 clk = ~clk;

    tile_draw_ctrl #(.TILE_COLS(TILE_COLS), .TILE_ROWS(TILE_ROWS)) dut (
        .clk(clk), .reset(reset), .start(start), .tile_col(tile_col), .tile_row(tile_row),
        .busy(busy), .done(done), .rom_x(rom_x), .rom_y(rom_y),
        .rom_r(rom_r), .rom_g(rom_g), .rom_b(rom_b),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic pix_t cur_pix();
        return {pix_x, pix_y, pix_r, pix_g, pix_b};
    endfunction

    task automatic fill_rand();
        for (int i = 0; i < 256; i++)
            rom_mem[i] = ($urandom_range(0, 7) == 0) ? 24'h0 : 24'($urandom);
    endtask

    // Exactly n black pixels at shuffled positions, the rest guaranteed non-black.
    task automatic fill_black(input int n);
        int idx[256];
        int j, t;
        for (int i = 0; i < 256; i++) idx[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = idx[i]; idx[i] = idx[j]; idx[j] = t;
        end
        for (int i = 0; i < 256; i++)
            rom_mem[idx[i]] = (i < n) ? 24'h0 : 24'($urandom_range(1, 24'hFFFFFF));
    endtask

    task automatic build_exp(input logic [5:0] col, input logic [4:0] row);
        exp_q = {};
        if (int'(col) < TILE_COLS && int'(row) < TILE_ROWS) begin
            for (int y = 0; y < 16; y++) begin
                for (int x = 0; x < 16; x++) begin
                    if (!(TRANSP && rom_mem[y * 16 + x] == 24'h0))
                        exp_q.push_back({10'(int'(col) * 16 + x), 9'(int'(row) * 16 + y),
                                         rom_mem[y * 16 + x]});
                end
            end
        end
    endtask

    // mode 0: ready held high, 1: ready high only before odd edges, 2: random ready
    task automatic run_tile(input logic [5:0] col, input logic [4:0] row, input int mode,
                            input bit inj);
        pix_t cur, held;
        bit   held_v, in_rng;
        int   k, stalls, hs, done_k, exp_n;
        in_rng = int'(col) < TILE_COLS && int'(row) < TILE_ROWS;
        build_exp(col, row);
        exp_n = exp_q.size();
        @(negedge clk);
        start = 1'b1; tile_col = col; tile_row = row; pix_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        stalls = 0; hs = 0; done_k = -1; held_v = 1'b0; held = '0; k = 1;
        while (done_k < 0 && k <= 1200) begin
            cur = cur_pix();
            if (held_v) chk("stall_hold", {pix_valid, cur}, {1'b1, held});
            if (done) begin
                done_k = k - 1;
            end else begin
                case (mode)
                    0:       pix_ready = 1'b1;
                    1:       pix_ready = (k % 2) == 1;
                    default: pix_ready = $urandom_range(0, 3) != 0;
                endcase
                start    = inj && (k == 50);
                tile_col = inj ? (col ^ 6'h15) : col;
                if (pix_valid && pix_ready) begin
                    hs++;
                    if (exp_q.size() == 0) chk("extra_pix", hs, exp_n);
                    else chk("pix", cur, exp_q.pop_front());
                end
                held_v = pix_valid && !pix_ready;
                held   = cur;
                if (held_v) stalls++;
                @(negedge clk);
                k++;
            end
        end
        start = 1'b0;
        tile_col = col;
        if (done_k < 0) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("done_edge", done_k, in_rng ? 257 + stalls : 1);
            chk("hs_count", hs, exp_n);
            if (mode == 1) chk("toggle_done_edge", done_k, 513);
            @(negedge clk);
            chk("after_done", {done, busy, pix_valid}, 3'b000);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int hs, k;
        reset = 1'b1; start = 1'b0; tile_col = '0; tile_row = '0; pix_ready = 1'b0;
        fill_rand();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", pix_valid, 0);
        chk("rst_rom_xy", {rom_x, rom_y}, 0);
        chk("rst_pix", cur_pix(), 0);
        reset = 1'b0;

        run_tile(6'd2, 5'd3, 0, 1'b0);
        fill_black(0);
        run_tile(6'd2, 5'd3, 1, 1'b0);
        fill_rand();
        run_tile(6'd2, 5'd3, 0, 1'b1);
        run_tile(6'd40, 5'd0, 0, 1'b0);
        run_tile(6'd0, 5'd30, 0, 1'b0);

        // Reset mid-tile after the 100th handshake
        fill_rand();
        build_exp(6'd1, 5'd2);
        @(negedge clk);
        start = 1'b1; tile_col = 6'd1; tile_row = 5'd2; pix_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; hs = 0; k = 0;
        while (hs < 100 && k < 600) begin
            if (pix_valid) begin
                hs++;
                chk("pix_pre_rst", cur_pix(), exp_q.pop_front());
            end
            k++;
            @(negedge clk);
        end
        chk("hs_before_rst", hs, 100);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_ctrl", {busy, done, pix_valid}, 3'b000);
        chk("midrst_pix", cur_pix(), 0);
        chk("midrst_rom_xy", {rom_x, rom_y}, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("abandoned", {busy, pix_valid}, 2'b00);
        run_tile(6'd0, 5'd0, 0, 1'b0);

        fill_black(200);
        run_tile(6'd7, 5'd9, 0, 1'b0);
        run_tile(6'd7, 5'd9, 2, 1'b0);
        fill_black(256);
        run_tile(6'd39, 5'd29, 0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            fill_rand();
            run_tile(6'($urandom_range(0, 39)), 5'($urandom_range(0, 29)), 2, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
